// File: rtl/home_pkg.sv
// -----------------------------------------------------------------------------
// home_pkg
// Shared definitions for the household load arbiter.
//   - requester index constants (bit positions in req/grant)
//   - per-slot FSM state encoding
//   - slot counter width
//   - popcount helper used for grant accounting
// -----------------------------------------------------------------------------
package home_pkg;

    localparam int HEAT   = 0;
    localparam int COOL   = 1;
    localparam int PUMP   = 2;
    localparam int SPRINK = 3;

    localparam int N_REQ = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ON_MIN  = 2'd1,
        S_ON_HOLD = 2'd2,
        S_LOCKOUT = 2'd3
    } slot_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/load_arbiter_if.sv
// -----------------------------------------------------------------------------
// load_arbiter_if
// Request/grant bundle between the load controllers and the arbiter.
//   req        [3:0] load requests (heat, cool, pump, sprinkler)
//   fire             emergency shed, active-high
//   grant      [3:0] registered grant per requester
//   active_cnt [2:0] registered number of set grant bits
//   waiting          registered: some requester is eligible-but-unserved
// master = load side (drives req/fire), slave = arbiter side.
// -----------------------------------------------------------------------------
interface load_arbiter_if;

    logic [3:0] req;
    logic       fire;
    logic [3:0] grant;
    logic [2:0] active_cnt;
    logic       waiting;

    modport master (output req, fire, input grant, active_cnt, waiting);
    modport slave  (input req, fire, output grant, active_cnt, waiting);

endinterface

// File: rtl/load_slot.sv
// -----------------------------------------------------------------------------
// load_slot
// Per-requester FSM (IDLE -> ON_MIN -> ON_HOLD -> LOCKOUT -> IDLE) with an
// 8-bit slot counter.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   i_req        this requester's request
//   i_fire       emergency shed (forces LOCKOUT)
//   i_award      arbiter awards a grant this cycle (only acted on in IDLE)
//   o_state      current state
//   o_state_nxt  state after the coming edge
//   o_grant      registered grant
//   o_releasing  slot leaves ON_HOLD on the coming edge
// Build option: LOAD_ARB_LOCKOUT_EN enables the LOCKOUT-cycle hold-off;
// without it LOCKOUT lasts a single cycle.
// -----------------------------------------------------------------------------
module load_slot
    import home_pkg::*;
#(
    parameter int MIN_ON  = 16,
    parameter int LOCKOUT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_fire,
    input  logic        i_award,
    output slot_state_t o_state,
    output slot_state_t o_state_nxt,
    output logic        o_grant,
    output logic        o_releasing
);

    if (MIN_ON < 1 || MIN_ON > 255) begin : g_bad_min_on
        $error("load_slot: MIN_ON out of range 1..255");
    end
    if (LOCKOUT < 1 || LOCKOUT > 255) begin : g_bad_lockout
        $error("load_slot: LOCKOUT out of range 1..255");
    end

    localparam logic [CNT_W-1:0] MIN_LOAD  = CNT_W'(MIN_ON - 1);
`ifdef LOAD_ARB_LOCKOUT_EN
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT - 1);
`else
    // A zero load makes LOCKOUT exit on the very next edge.
    localparam logic [CNT_W-1:0] LOCK_LOAD = '0;
`endif

    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_grant;

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_fire) begin
            // Pinned here while fire is high, so countdown begins after it drops.
            w_state_nxt = S_LOCKOUT;
            w_cnt_nxt   = LOCK_LOAD;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_award) begin
                        w_state_nxt = S_ON_MIN;
                        w_cnt_nxt   = MIN_LOAD;
                    end
                end
                S_ON_MIN: begin
                    // req is deliberately ignored until the minimum time expires.
                    if (r_cnt == '0) w_state_nxt = S_ON_HOLD;
                    else             w_cnt_nxt   = r_cnt - 1'b1;
                end
                S_ON_HOLD: begin
                    if (!i_req) begin
                        w_state_nxt = S_LOCKOUT;
                        w_cnt_nxt   = LOCK_LOAD;
                    end
                end
                S_LOCKOUT: begin
                    if (r_cnt == '0) w_state_nxt = S_IDLE;
                    else             w_cnt_nxt   = r_cnt - 1'b1;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_grant <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= (w_state_nxt == S_ON_MIN) || (w_state_nxt == S_ON_HOLD);
        end
    end

    assign o_state     = r_state;
    assign o_state_nxt = w_state_nxt;
    assign o_grant     = r_grant;
    assign o_releasing = (r_state == S_ON_HOLD) && !i_req;

endmodule

// File: rtl/load_arbiter.sv
// -----------------------------------------------------------------------------
// load_arbiter
// Grants up to MAX_ON of four household loads at once, each for at least
// MIN_ON cycles, with a LOCKOUT hold-off before a released load may return.
// Heat and cool are mutually exclusive. fire sheds every load immediately.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset
//   bus    load_arbiter_if.slave (req, fire in; grant, active_cnt, waiting out)
// Build option: LOAD_ARB_LOCKOUT_EN (see load_slot).
// -----------------------------------------------------------------------------
module load_arbiter
    import home_pkg::*;
#(
    parameter int MAX_ON  = 2,
    parameter int MIN_ON  = 16,
    parameter int LOCKOUT = 32
) (
    input  logic           clk,
    input  logic           reset,
    load_arbiter_if.slave  bus
);

    if (MAX_ON < 1 || MAX_ON > 4) begin : g_bad_max_on
        $error("load_arbiter: MAX_ON out of range 1..4");
    end

    slot_state_t w_state     [N_REQ];
    slot_state_t w_state_nxt [N_REQ];
    logic [3:0]  w_grant;
    logic [3:0]  w_releasing;
    logic [3:0]  w_award;
    logic [3:0]  w_elig;
    logic [3:0]  w_grant_nxt;
    logic [3:0]  w_lock_nxt;
    logic [2:0]  w_remaining;
    logic [1:0]  w_idx;
    logic        w_found;
    logic [1:0]  w_ptr_nxt;

    logic [1:0]  r_ptr;
    logic [2:0]  r_active_cnt;
    logic        r_waiting;

    for (genvar g = 0; g < N_REQ; g++) begin : g_slot
        load_slot #(
            .MIN_ON  (MIN_ON),
            .LOCKOUT (LOCKOUT)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .i_req       (bus.req[g]),
            .i_fire      (bus.fire),
            .i_award     (w_award[g]),
            .o_state     (w_state[g]),
            .o_state_nxt (w_state_nxt[g]),
            .o_grant     (w_grant[g]),
            .o_releasing (w_releasing[g])
        );
        assign w_elig[g]      = (w_state[g] == S_IDLE) && bus.req[g];
        assign w_grant_nxt[g] = (w_state_nxt[g] == S_ON_MIN) || (w_state_nxt[g] == S_ON_HOLD);
        assign w_lock_nxt[g]  = (w_state_nxt[g] == S_LOCKOUT);
    end

    // Releasing slots are always a subset of granted ones, so no underflow.
    assign w_remaining = popcount4(w_grant) - popcount4(w_releasing);

    always_comb begin
        w_award   = '0;
        w_found   = 1'b0;
        w_ptr_nxt = r_ptr;
        w_idx     = r_ptr;
        if (!bus.fire && (w_remaining < 3'(MAX_ON))) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_idx = r_ptr + 2'(k);
                // Heat/cool interlock: a granted partner blocks the other,
                // even on the edge it releases.
                if (!w_found && w_elig[w_idx]
                    && !(w_idx == 2'(HEAT) && w_grant[COOL])
                    && !(w_idx == 2'(COOL) && w_grant[HEAT])) begin
                    w_award[w_idx] = 1'b1;
                    w_found        = 1'b1;
                    w_ptr_nxt      = w_idx + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr        <= 2'd0;
            r_active_cnt <= 3'd0;
            r_waiting    <= 1'b0;
        end else begin
            r_ptr        <= w_ptr_nxt;
            r_active_cnt <= popcount4(w_grant_nxt);
            r_waiting    <= |(bus.req & ~w_grant_nxt & ~w_lock_nxt);
        end
    end

    assign bus.grant      = w_grant;
    assign bus.active_cnt = r_active_cnt;
    assign bus.waiting    = r_waiting;

endmodule

// File: tb/tb_load_arbiter.sv
// -----------------------------------------------------------------------------
// tb_load_arbiter
// Directed bench for load_arbiter. Instance A uses the default parameters,
// instance B uses MAX_ON=1, MIN_ON=2, LOCKOUT=3 for the alternation test.
// Expected outputs are queued when a step is driven and compared one cycle
// later, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_load_arbiter;

`ifdef LOAD_ARB_LOCKOUT_EN
    localparam int LOCK_CYC = 32;
`else
    localparam int LOCK_CYC = 1;
`endif

    typedef struct {
        string      tag;
        bit         sel_b;
        logic [3:0] grant;
        logic [2:0] cnt;
        logic       wt;
        bit         chk_wt;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    exp_t sb[$];
    int   n_pass;
    int   n_fail;
    int   n_checks;

    load_arbiter_if if_a ();
    load_arbiter_if if_b ();

    load_arbiter #(.MAX_ON(2), .MIN_ON(16), .LOCKOUT(32)) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (if_a.slave)
    );

    load_arbiter #(.MAX_ON(1), .MIN_ON(2), .LOCKOUT(3)) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out();
        exp_t       e;
        logic [3:0] g;
        logic [2:0] c;
        logic       w;
        e = sb.pop_front();
        if (e.sel_b) begin
            g = if_b.grant; c = if_b.active_cnt; w = if_b.waiting;
        end else begin
            g = if_a.grant; c = if_a.active_cnt; w = if_a.waiting;
        end
        n_checks++;
        assert (g === e.grant) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s grant: observed %b expected %b", e.tag, g, e.grant);
        end
        n_checks++;
        assert (c === e.cnt) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s active_cnt: observed %0d expected %0d", e.tag, c, e.cnt);
        end
        if (e.chk_wt) begin
            n_checks++;
            assert (w === e.wt) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s waiting: observed %b expected %b", e.tag, w, e.wt);
            end
        end
    endtask

    task automatic step(input bit sel_b, input logic rst, input logic [3:0] rq,
                        input logic fi, input string tag, input logic [3:0] eg,
                        input logic [2:0] ec, input logic ew, input bit cw);
        exp_t e;
        if (sel_b) begin
            rst_b = rst; if_b.req = rq; if_b.fire = fi;
        end else begin
            rst_a = rst; if_a.req = rq; if_a.fire = fi;
        end
        e.tag = tag; e.sel_b = sel_b; e.grant = eg; e.cnt = ec; e.wt = ew; e.chk_wt = cw;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // From reset: grant rq, drop req on cycle 3, release after MIN_ON,
    // re-request, expect re-grant only once the lockout has run out.
    task automatic release_seq(input logic [3:0] rq, input string tag);
        step(0, 1, rq, 0, {tag, "_e1"}, rq, 1, 0, 1);
        step(0, 1, rq, 0, {tag, "_e2"}, rq, 1, 0, 1);
        for (int i = 3; i <= 17; i++) step(0, 1, 4'b0000, 0, {tag, "_min"}, rq, 1, 0, 1);
        step(0, 1, 4'b0000, 0, {tag, "_drop"}, 4'b0000, 0, 0, 1);
        for (int i = 1; i < LOCK_CYC; i++) step(0, 1, rq, 0, {tag, "_lock"}, 4'b0000, 0, 0, 1);
        step(0, 1, rq, 0, {tag, "_idle"}, 4'b0000, 0, 1, 1);
        step(0, 1, rq, 0, {tag, "_regrant"}, rq, 1, 0, 1);
    endtask

    initial begin
        logic [3:0] holder;
        logic [3:0] other;
        n_pass = 0; n_fail = 0; n_checks = 0;
        rst_a = 1'b0; rst_b = 1'b0;
        if_a.req = '0; if_a.fire = 1'b0;
        if_b.req = '0; if_b.fire = 1'b0;

        // Reset state, including reset overriding fire and requests.
        step(0, 0, 4'b0000, 0, "rst0", 4'b0000, 0, 0, 1);
        step(0, 0, 4'b1111, 1, "rst_fire", 4'b0000, 0, 0, 1);

        // Test 1: all requesting; cool blocked by heat.
        step(0, 1, 4'b1111, 0, "t1_e1", 4'b0001, 1, 1, 1);
        step(0, 1, 4'b1111, 0, "t1_e2", 4'b0101, 2, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 4'b1111, 0, "t1_hold", 4'b0101, 2, 1, 1);
        step(0, 0, 4'b1111, 0, "t1_rst", 4'b0000, 0, 0, 1);

        // Test 2: heat release after MIN_ON, then lockout.
        release_seq(4'b0001, "t2");
        step(0, 0, 4'b0000, 0, "t2_rst", 4'b0000, 0, 0, 1);

        // Test 3: fire while heat and pump are in ON_MIN.
        step(0, 1, 4'b0101, 0, "t3_e1", 4'b0001, 1, 1, 1);
        step(0, 1, 4'b0101, 0, "t3_e2", 4'b0101, 2, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 4'b0101, 1, "t3_fire", 4'b0000, 0, 0, 1);
        for (int i = 1; i < LOCK_CYC; i++) step(0, 1, 4'b0101, 0, "t3_lock", 4'b0000, 0, 0, 1);
        step(0, 1, 4'b0101, 0, "t3_idle", 4'b0000, 0, 1, 1);
        step(0, 1, 4'b0101, 0, "t3_award1", 4'b0001, 1, 1, 1);
        step(0, 1, 4'b0101, 0, "t3_award2", 4'b0101, 2, 0, 1);
        step(0, 0, 4'b0000, 0, "t3_rst", 4'b0000, 0, 0, 1);

        // Test 5: reset in the middle of a fire-induced lockout.
        step(0, 1, 4'b0100, 0, "t5_grant", 4'b0100, 1, 0, 1);
        step(0, 1, 4'b0100, 1, "t5_fire", 4'b0000, 0, 0, 1);
        step(0, 0, 4'b0100, 0, "t5_rst", 4'b0000, 0, 0, 1);
        step(0, 1, 4'b0100, 0, "t5_first", 4'b0100, 1, 0, 1);

`ifndef LOAD_ARB_LOCKOUT_EN
        // Test 6: single-cycle lockout, pump re-granted two edges after release.
        step(0, 0, 4'b0000, 0, "t6_rst", 4'b0000, 0, 0, 1);
        release_seq(4'b0100, "t6");
`endif

        // Test 4: MAX_ON=1, pump and sprinkler alternate via round-robin.
        step(1, 0, 4'b1100, 0, "t4_rst", 4'b0000, 0, 0, 1);
        step(1, 1, 4'b1100, 0, "t4_first", 4'b0100, 1, 0, 0);
        holder = 4'b0100;
        for (int p = 0; p < 4; p++) begin
            other = 4'b1100 & ~holder;
            for (int i = 0; i < 6; i++) step(1, 1, 4'b1100, 0, "t4_hold", holder, 1, 0, 0);
            step(1, 1, other, 0, "t4_swap", other, 1, 0, 0);
            holder = other;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
